branch_resolve_unit: RTL and testbench

- Parametrised, registered successor to the combinational jump calculator.
- Takes one decoded instruction per cycle from decode and resolves the branch decision and target for all branch classes: unconditional, conditional (8 conditions), call and return.
- Holds call return addresses in an internal return-address stack (RAS).
- Presents a registered redirect to fetch, with stall and flush control from the pipeline controller.

---
 rtl/branch_resolve_unit.sv | 146 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch resolver with return-address stack
module branch_resolve_unit #(
    parameter int PC_W      = 12,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [PC_W-1:0]                in_pc,
    input  logic [15:0]                    in_instr,
    input  logic [3:0]                     in_szcv,
    input  logic                           stall,
    input  logic                           flush,
    output logic                           out_valid,
    output logic                           out_taken,
    output logic [PC_W-1:0]                out_dest,
    output logic                           out_err,
    output logic [$clog2(RAS_DEPTH):0]     ras_count
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [4:0] OP_JMP  = 5'b10100;
    localparam logic [4:0] OP_CALL = 5'b10101;
    localparam logic [4:0] OP_RET  = 5'b10110;
    localparam logic [4:0] OP_BCC  = 5'b10111;

    logic [PC_W-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;

    logic [4:0]      opcode;
    logic [PC_W-1:0] disp;
    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] tgt;
    logic            fs, fz, fc, fv;
    logic            cond_true;
    logic            dec_taken;
    logic [PC_W-1:0] dec_dest;
    logic            dec_err;
    logic            capture;
    logic            do_push;
    logic            do_pop;
    logic            ras_empty;
    logic            ras_full;

    assign opcode    = in_instr[15:11];
    assign disp      = {{(PC_W-8){in_instr[7]}}, in_instr[7:0]};
    assign seq       = in_pc + PC_W'(1);
    assign tgt       = in_pc + disp + PC_W'(1);
    assign {fs, fz, fc, fv} = in_szcv;
    assign ptr_inc   = ras_ptr + PW'(1);
    assign ptr_dec   = ras_ptr - PW'(1);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));
    assign capture   = !stall && !flush;

    // Evaluate the 3-bit branch condition against the incoming flags.
    always_comb begin
        cond_true = 1'b0;
        case (in_instr[10:8])
            3'b000:  cond_true = fz;
            3'b001:  cond_true = fs ^ fv;
            3'b010:  cond_true = fz | (fs ^ fv);
            3'b011:  cond_true = !fz;
            3'b100:  cond_true = !(fs ^ fv);
            3'b101:  cond_true = !fz && !(fs ^ fv);
            3'b110:  cond_true = fc;
            default: cond_true = !fc;
        endcase
    end

    // Decode the branch class into taken/dest/err; non-branches fall through to seq.
    always_comb begin
        dec_taken = 1'b0;
        dec_dest  = seq;
        dec_err   = 1'b0;
        if (in_valid) begin
            case (opcode)
                OP_JMP, OP_CALL: begin
                    dec_taken = 1'b1;
                    dec_dest  = tgt;
                end
                OP_RET: begin
                    dec_taken = 1'b1;
                    if (ras_empty) begin
                        dec_err = 1'b1;
                    end else begin
                        dec_dest = ras_mem[ptr_dec];
                    end
                end
                OP_BCC: begin
                    dec_taken = cond_true;
                    dec_dest  = cond_true ? tgt : seq;
                end
                default: ;
            endcase
        end
    end

    assign do_push = capture && in_valid && (opcode == OP_CALL);
    assign do_pop  = capture && in_valid && (opcode == OP_RET) && !ras_empty;

    // Output register: capture, hold on stall, kill valid/taken/err on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_taken <= 1'b0;
            out_dest  <= '0;
            out_err   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_taken <= 1'b0;
            out_err   <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_taken <= dec_taken;
            out_dest  <= dec_dest;
            out_err   <= dec_err;
        end
    end

    // RAS pointer and occupancy; a push when full overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (do_push) begin
            ras_ptr <= ptr_inc;
            if (!ras_full) begin
                ras_count <= ras_count + CW'(1);
            end
        end else if (do_pop) begin
            ras_ptr   <= ptr_dec;
            ras_count <= ras_count - CW'(1);
        end
    end

    // RAS storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            ras_mem[ras_ptr] <= seq;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_pc = '0;
    logic [15:0] in_instr = '0;
    logic [3:0]  in_szcv = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_taken;
    logic [11:0] out_dest;
    logic        out_err;
    logic [2:0]  ras_count;

    int checks = 0;
    int failures = 0;

    branch_resolve_unit #(.PC_W(12), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .in_instr(in_instr), .in_szcv(in_szcv), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_taken(out_taken), .out_dest(out_dest),
        .out_err(out_err), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [11:0] pc, input logic [15:0] ins,
                        input logic [3:0] f, input logic st, input logic fl);
        @(negedge clk);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
        in_szcv  = f;
        stall    = st;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] jmp(input logic [7:0] d);
        return {5'b10100, 3'b000, d};
    endfunction
    function automatic logic [15:0] call(input logic [7:0] d);
        return {5'b10101, 3'b000, d};
    endfunction
    function automatic logic [15:0] ret();
        return {5'b10110, 11'h000};
    endfunction
    function automatic logic [15:0] bcc(input logic [2:0] c, input logic [7:0] d);
        return {5'b10111, c, d};
    endfunction

    function automatic logic cond_model(input logic [2:0] c, input logic [3:0] f);
        logic s, z, cy, v;
        {s, z, cy, v} = f;
        case (c)
            3'd0: return z;
            3'd1: return s ^ v;
            3'd2: return z | (s ^ v);
            3'd3: return !z;
            3'd4: return !(s ^ v);
            3'd5: return !z && !(s ^ v);
            3'd6: return cy;
            default: return !cy;
        endcase
    endfunction

    logic [11:0] ret_exp [4];

    initial begin
        // Reset
        step(1'b0, 12'h000, 16'h0000, 4'h0, 1'b0, 1'b0);
        step(1'b0, 12'h000, 16'h0000, 4'h0, 1'b0, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_taken", 32'(out_taken), 32'd0);
        chk("rst_dest", 32'(out_dest), 32'h000);
        chk("rst_err", 32'(out_err), 32'd0);
        chk("rst_count", 32'(ras_count), 32'd0);
        rst = 1'b0;

        // JMP, negative displacement and wrap-around
        step(1'b1, 12'h010, jmp(8'hFE), 4'h0, 1'b0, 1'b0);
        chk("jmp_valid", 32'(out_valid), 32'd1);
        chk("jmp_taken", 32'(out_taken), 32'd1);
        chk("jmp_dest", 32'(out_dest), 32'h00F);
        step(1'b1, 12'hFFF, jmp(8'h01), 4'h0, 1'b0, 1'b0);
        chk("jmp_wrap_dest", 32'(out_dest), 32'h001);

        // Bcc sweep over all conditions and flag combinations
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 16; f++) begin
                logic t;
                t = cond_model(3'(c), 4'(f));
                step(1'b1, 12'h100, bcc(3'(c), 8'h10), 4'(f), 1'b0, 1'b0);
                chk($sformatf("bcc%0d_f%0h_taken", c, f), 32'(out_taken), 32'(t));
                chk($sformatf("bcc%0d_f%0h_dest", c, f), 32'(out_dest), t ? 32'h111 : 32'h101);
            end
        end

        // Taken followed by false condition: taken must drop
        step(1'b1, 12'h100, bcc(3'd0, 8'h10), 4'b0100, 1'b0, 1'b0);
        chk("nolatch_pre_taken", 32'(out_taken), 32'd1);
        step(1'b1, 12'h100, bcc(3'd3, 8'h10), 4'b0100, 1'b0, 1'b0);
        chk("nolatch_taken", 32'(out_taken), 32'd0);
        chk("nolatch_dest", 32'(out_dest), 32'h101);

        // Non-branch and invalid slots
        step(1'b1, 12'h234, 16'h0000, 4'h0, 1'b0, 1'b0);
        chk("other_taken", 32'(out_taken), 32'd0);
        chk("other_dest", 32'(out_dest), 32'h235);
        step(1'b0, 12'h234, jmp(8'h05), 4'h0, 1'b0, 1'b0);
        chk("inv_valid", 32'(out_valid), 32'd0);
        chk("inv_taken", 32'(out_taken), 32'd0);
        chk("inv_dest", 32'(out_dest), 32'h235);

        // RAS fill with overflow, then drain and underflow
        for (int i = 0; i < 5; i++) begin
            logic [11:0] pc;
            pc = 12'h020 + 12'(i * 16);
            step(1'b1, pc, call(8'h00), 4'h0, 1'b0, 1'b0);
            chk($sformatf("call%0d_dest", i), 32'(out_dest), 32'(pc + 12'h001));
            chk($sformatf("call%0d_count", i), 32'(ras_count), (i < 4) ? 32'(i + 1) : 32'd4);
        end
        ret_exp[0] = 12'h061;
        ret_exp[1] = 12'h051;
        ret_exp[2] = 12'h041;
        ret_exp[3] = 12'h031;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 12'h300, ret(), 4'h0, 1'b0, 1'b0);
            chk($sformatf("ret%0d_dest", i), 32'(out_dest), 32'(ret_exp[i]));
            chk($sformatf("ret%0d_err", i), 32'(out_err), 32'd0);
            chk($sformatf("ret%0d_count", i), 32'(ras_count), 32'(3 - i));
        end
        step(1'b1, 12'h300, ret(), 4'h0, 1'b0, 1'b0);
        chk("ret_empty_dest", 32'(out_dest), 32'h301);
        chk("ret_empty_err", 32'(out_err), 32'd1);
        chk("ret_empty_taken", 32'(out_taken), 32'd1);
        chk("ret_empty_count", 32'(ras_count), 32'd0);

        // Back-to-back CALL then RET
        step(1'b1, 12'h200, call(8'h40), 4'h0, 1'b0, 1'b0);
        chk("b2b_call_count", 32'(ras_count), 32'd1);
        chk("b2b_call_dest", 32'(out_dest), 32'h241);
        step(1'b1, 12'h2A0, ret(), 4'h0, 1'b0, 1'b0);
        chk("b2b_ret_dest", 32'(out_dest), 32'h201);
        chk("b2b_ret_err", 32'(out_err), 32'd0);
        chk("b2b_ret_count", 32'(ras_count), 32'd0);

        // Stall holds outputs and RAS, single push on release
        step(1'b1, 12'h010, jmp(8'hFE), 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 12'h400, call(8'h00), 4'h0, 1'b1, 1'b0);
            chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_dest", i), 32'(out_dest), 32'h00F);
            chk($sformatf("stall%0d_count", i), 32'(ras_count), 32'd0);
        end
        step(1'b1, 12'h400, call(8'h00), 4'h0, 1'b0, 1'b0);
        chk("release_dest", 32'(out_dest), 32'h401);
        chk("release_count", 32'(ras_count), 32'd1);
        step(1'b0, 12'h123, 16'h0000, 4'h0, 1'b0, 1'b0);
        chk("post_release_count", 32'(ras_count), 32'd1);
        chk("post_release_dest", 32'(out_dest), 32'h124);

        // Flush kills the capture and leaves the RAS alone
        step(1'b1, 12'h500, call(8'h00), 4'h0, 1'b0, 1'b1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_taken", 32'(out_taken), 32'd0);
        chk("flush_dest", 32'(out_dest), 32'h124);
        chk("flush_count", 32'(ras_count), 32'd1);
        step(1'b1, 12'h500, call(8'h00), 4'h0, 1'b1, 1'b1);
        chk("flush_stall_count", 32'(ras_count), 32'd1);
        chk("flush_stall_valid", 32'(out_valid), 32'd0);

        // Reset with a full RAS while stalled
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 12'h600, call(8'h00), 4'h0, 1'b0, 1'b0);
        end
        chk("full_count", 32'(ras_count), 32'd4);
        rst = 1'b1;
        step(1'b1, 12'h600, call(8'h00), 4'h0, 1'b1, 1'b0);
        chk("rst_full_count", 32'(ras_count), 32'd0);
        chk("rst_full_valid", 32'(out_valid), 32'd0);
        chk("rst_full_dest", 32'(out_dest), 32'h000);
        rst = 1'b0;
        step(1'b1, 12'h700, ret(), 4'h0, 1'b0, 1'b0);
        chk("post_rst_ret_err", 32'(out_err), 32'd1);
        chk("post_rst_ret_dest", 32'(out_dest), 32'h701);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
